rx_controller: RTL

- Sequencing controller that sits between the UART receiver (req/ack/data[7:0]) and the host-side logic.
- Completes the receiver's four-phase req/ack handshake and buffers received bytes in a small FIFO.
- Presents buffered bytes to the host through a valid/ready read port.
- Flags overrun (byte lost because the FIFO was full) and handshake timeout (receiver never dropped req); both flags are sticky.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_fifo.sv | 75 +++++++
 rtl/rx_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller state encoding
// and default widths.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      ERR  = 2'd2
   } rx_state_t;

   localparam int DW_DEFAULT = 8;
   localparam int DROP_W     = 8;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO with a separate occupancy counter and a registered head
// entry, so the read data comes straight from a flop.
module rx_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic [DW-1:0]            din,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [DW-1:0]            head
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] rptr_nx;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rptr_nx = rptr + 1'b1;

   // A push into a full FIFO is only accepted when the head leaves this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         head  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr_nx;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
         // The head follows the oldest entry; when the popped entry was the
         // only one, a same-cycle push becomes the new head directly.
         if (do_pop) begin
            if (count > (AW+1)'(1)) begin
               head <= mem[rptr_nx];
            end else if (do_push) begin
               head <= din;
            end
         end else if (do_push && empty) begin
            head <= din;
         end
      end
   end

endmodule

// File: rtl/rx_controller.sv
// Completes the UART receiver's four-phase req/ack handshake, buffers bytes
// in rx_fifo and tracks sticky overrun / handshake-timeout errors.
module rx_controller
   import uart_pkg::*;
#(
   parameter int DW          = DW_DEFAULT,
   parameter int DEPTH       = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     req,
   input  logic [DW-1:0]            data,
   output logic                     ack,
   output logic [DW-1:0]            rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overrun,
   output logic [DROP_W-1:0]        drop_cnt,
   output logic                     hs_err,
   input  logic                     err_clr
);

   localparam int             TW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(ACK_TIMEOUT - 1);

   rx_state_t     state;
   rx_state_t     state_nxt;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_nxt;
   logic          capture;
   logic          hs_set;
   logic          pop_fire;
   logic          fifo_full;
   logic          fifo_empty;
   logic          slot_free;
   logic          accept;
   logic          drop;

   // Host side: valid/ready; a byte transfers on any edge where both are 1.
   assign pop_fire  = rd_valid && rd_ready;
   assign rd_valid  = !fifo_empty;
   assign slot_free = !fifo_full || pop_fire;
   assign accept    = capture && slot_free;
   assign drop      = capture && !slot_free;

   // ack decodes the state register only, so it never depends on req combinationally.
   assign ack = (state == ACK);

   rx_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (accept),
      .din   (data),
      .pop   (pop_fire),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level),
      .head  (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      capture   = 1'b0;
      hs_set    = 1'b0;
      case (state)
         IDLE: begin
            tcnt_nxt = '0;
            if (req) begin
               capture   = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            if (!req) begin
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end else if (tcnt == TO_LAST) begin
               state_nxt = ERR;
               hs_set    = 1'b1;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         ERR: begin
            tcnt_nxt = '0;
            if (!req) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            tcnt_nxt  = '0;
         end
      endcase
   end

   // A new error in the same cycle as err_clr wins over the clear.
   always_ff @(posedge clk) begin
      if (!clr) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
         hs_err   <= 1'b0;
      end else begin
         overrun <= (overrun && !err_clr) || drop;
         hs_err  <= (hs_err && !err_clr) || hs_set;
         if (err_clr) begin
            drop_cnt <= {{(DROP_W-1){1'b0}}, drop};
         end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule
